// File: rtl/ram_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dump_reader_if
//  Description : RAM port and word output stream of the RAM dump reader.
//                The master side is the reader; the slave side is the RAM
//                plus the downstream consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_dump_reader_if;
  logic [15:0] ram_address;
  logic        ram_rw;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;
  logic [15:0] out_data;
  logic [15:0] out_addr;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output ram_address, ram_rw, ram_data_in,
    output out_data, out_addr, out_valid,
    input  ram_data_out, out_ready
  );

  modport slave (
    input  ram_address, ram_rw, ram_data_in,
    input  out_data, out_addr, out_valid,
    output ram_data_out, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dump_reader
//  Description : Read-only initiator on the 16-bit RAM port. Walks a
//                contiguous address range after a start pulse and streams
//                each word, tagged with its address, on a valid/ready port.
//                READ_LATENCY is the number of rising edges from an address
//                change until the RAM output holds that word (1..4).
//  Revision    : 1.0  initial release
// ============================================================================
module ram_dump_reader #(
  parameter int READ_LATENCY = 1
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic [15:0] base_addr,
  input  wire logic [15:0] word_count,
  output logic             busy,
  output logic             done,
  ram_dump_reader_if.master bus
);

  // Counter wide enough for the largest legal latency (4).
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state,      state_next;
  logic [15:0] address,    address_next;
  logic [15:0] remaining,  remaining_next;
  logic [2:0]  lat_cnt,    lat_cnt_next;
  logic [15:0] data_reg,   data_next;
  logic [15:0] addr_reg,   addr_next;
  logic        valid_reg,  valid_next;
  logic        busy_reg,   busy_next;
  logic        done_reg,   done_next;

  // State and every output are registered; next values come from the block below.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      address   <= 16'h0000;
      remaining <= 16'h0000;
      lat_cnt   <= 3'd0;
      data_reg  <= 16'h0000;
      addr_reg  <= 16'h0000;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_next;
      address   <= address_next;
      remaining <= remaining_next;
      lat_cnt   <= lat_cnt_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and next-output decode; done is a pulse, so it defaults low.
  always_comb begin
    state_next     = state;
    address_next   = address;
    remaining_next = remaining;
    lat_cnt_next   = lat_cnt;
    data_next      = data_reg;
    addr_next      = addr_reg;
    valid_next     = valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_next = 1'b1;
          if (word_count == 16'h0000) begin
            // Empty transfer still reports completion one cycle later.
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            address_next   = base_addr;
            remaining_next = word_count;
            lat_cnt_next   = LAT_LOAD;
            state_next     = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // The extra edge after the counter reaches zero gives the RAM its full latency.
        if (lat_cnt == 3'd0) begin
          data_next  = bus.ram_data_out;
          addr_next  = address;
          valid_next = 1'b1;
          state_next = S_HOLD;
        end else begin
          lat_cnt_next = lat_cnt - 3'd1;
        end
      end

      S_HOLD: begin
        if (valid_reg && bus.out_ready) begin
          valid_next     = 1'b0;
          remaining_next = remaining - 16'd1;
          if (remaining == 16'd1) begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            // 16-bit add wraps FFFF to 0000 naturally.
            address_next = address + 16'd1;
            lat_cnt_next = LAT_LOAD;
            state_next   = S_WAIT;
          end
        end
      end

      S_DONE: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign bus.ram_address = address;
  assign bus.ram_rw      = 1'b0;
  assign bus.ram_data_in = 16'h0000;
  assign bus.out_data    = data_reg;
  assign bus.out_addr    = addr_reg;
  assign bus.out_valid   = valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_ram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dump_reader
//  Description : Drives four readers (READ_LATENCY 1..4) with shared
//                stimulus and checks every streamed word, its timing and the
//                done/busy behaviour against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_dump_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic [15:0] word_count = 16'h0000;
  logic        ready = 1'b1;
  logic [15:0] key = 16'hA5A5;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic        busy_w [4];
  logic        done_w [4];
  logic        valid_w[4];
  logic        rrw_w  [4];
  logic [15:0] oaddr_w[4];
  logic [15:0] odata_w[4];
  logic [15:0] raddr_w[4];
  logic [15:0] rdin_w [4];

  logic [15:0] log_addr[4][$];
  logic [15:0] log_data[4][$];
  int          log_cyc [4][$];
  int          done_cnt[4];
  int          done_cyc[4];
  int          busy_cnt[4];

  // Free-running clock and cycle index.
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ram_dump_reader_if ifc ();
    logic        busy;
    logic        done;
    logic [15:0] pipe [k+1];

    ram_dump_reader #(.READ_LATENCY(k + 1)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .bus        (ifc)
    );

    // RAM model: contents are address ^ key, output delayed by k+1 edges.
    always @(posedge clock) begin
      pipe[0] <= ifc.ram_address ^ key;
      for (int j = 1; j <= k; j++) pipe[j] <= pipe[j-1];
    end

    assign ifc.ram_data_out = pipe[k];
    assign ifc.out_ready    = ready;
    assign busy_w[k]  = busy;
    assign done_w[k]  = done;
    assign valid_w[k] = ifc.out_valid;
    assign rrw_w[k]   = ifc.ram_rw;
    assign oaddr_w[k] = ifc.out_addr;
    assign odata_w[k] = ifc.out_data;
    assign raddr_w[k] = ifc.ram_address;
    assign rdin_w[k]  = ifc.ram_data_in;
  end

  // Monitor: logs accepted words, done pulses and busy cycles per instance.
  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (valid_w[k] && ready) begin
        log_addr[k].push_back(oaddr_w[k]);
        log_data[k].push_back(odata_w[k]);
        log_cyc[k].push_back(cyc);
      end
      if (done_w[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      if (busy_w[k]) busy_cnt[k]++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_outs_L%0d", tag, k + 1),
          {busy_w[k], done_w[k], valid_w[k], rrw_w[k], odata_w[k], oaddr_w[k], raddr_w[k]},
          64'h0);
      chk($sformatf("%s_wdata_L%0d", tag, k + 1), rdin_w[k], 64'h0);
    end
  endtask

  // mode 0: ready held high (timing checked); 1: 5-cycle stall on word 2 of L=1;
  // 2: random ready. ign pulses a second start mid-transfer.
  task automatic run_xfer(input logic [15:0] b, input logic [15:0] n, input int mode, input bit ign);
    int lo[4];
    int dlo[4];
    int blo[4];
    int e0;
    int t;
    int stall_left;
    int got;
    int lat;
    bit all;
    bit stalled;
    logic [15:0] a;
    for (int k = 0; k < 4; k++) begin
      lo[k]  = log_addr[k].size();
      dlo[k] = done_cnt[k];
      blo[k] = busy_cnt[k];
    end
    ready      = 1'b1;
    start      = 1'b1;
    base_addr  = b;
    word_count = n;
    e0         = cyc + 1;
    step();
    start      = 1'b0;
    base_addr  = 16'($urandom);
    word_count = 16'($urandom);
    t = 0; stall_left = 0; stalled = 1'b0; all = 1'b0;
    while (t < 800) begin
      all = 1'b1;
      for (int k = 0; k < 4; k++) if (done_cnt[k] == dlo[k]) all = 1'b0;
      if (all) break;
      if (mode == 1) begin
        if (!stalled && valid_w[0] && (log_addr[0].size() == lo[0] + 1)) begin
          stalled    = 1'b1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          chk("stall_hold", {valid_w[0], oaddr_w[0], odata_w[0], raddr_w[0]},
              {1'b1, b + 16'd1, (b + 16'd1) ^ key, b + 16'd1});
          stall_left--;
          ready = 1'b0;
        end else begin
          ready = 1'b1;
        end
      end else if (mode == 2) begin
        ready = 1'($urandom_range(0, 1));
      end
      if (ign) begin
        start      = (t == 3);
        base_addr  = 16'h1234;
        word_count = 16'd7;
      end
      step();
      t++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("xfer_completed_in_budget", all, 1);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      lat = k + 1;
      got = log_addr[k].size() - lo[k];
      chk($sformatf("word_count_L%0d", lat), got, n);
      for (int i = 0; i < n && i < got; i++) begin
        a = b + 16'(i);
        chk($sformatf("addr_L%0d_w%0d", lat, i), log_addr[k][lo[k] + i], a);
        chk($sformatf("data_L%0d_w%0d", lat, i), log_data[k][lo[k] + i], a ^ key);
        if (mode == 0)
          chk($sformatf("hs_cycle_L%0d_w%0d", lat, i), log_cyc[k][lo[k] + i],
              e0 + (lat + 2) * (i + 1) - 1);
      end
      chk($sformatf("done_pulses_L%0d", lat), done_cnt[k] - dlo[k], 1);
      if (mode == 0) begin
        chk($sformatf("done_cycle_L%0d", lat), done_cyc[k], e0 + n * (lat + 2));
        chk($sformatf("busy_cycles_L%0d", lat), busy_cnt[k] - blo[k], n * (lat + 2) + 1);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    int dlo[4];
    int lo[4];
    for (int k = 0; k < 4; k++) begin
      dlo[k] = done_cnt[k];
      lo[k]  = log_addr[k].size();
    end
    repeat (12) step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_no_done_L%0d", tag, k + 1), done_cnt[k] - dlo[k], 0);
      chk($sformatf("%s_no_words_L%0d", tag, k + 1), log_addr[k].size() - lo[k], 0);
    end
  endtask

  initial begin
    int w;
    // Power-on reset.
    reset = 1'b1;
    repeat (3) step();
    check_reset_vals("reset_init");
    reset = 1'b0;
    step();

    // Basic read, backpressure, wrap-around, zero count, ignored start.
    key = 16'hA5A5;
    run_xfer(16'h0010, 16'd4, 0, 1'b0);
    run_xfer(16'h0010, 16'd4, 1, 1'b0);
    run_xfer(16'hFFFE, 16'd3, 0, 1'b0);
    run_xfer(16'h0050, 16'd0, 0, 1'b0);
    run_xfer(16'h0100, 16'd4, 0, 1'b1);

    // Reset while every instance is waiting on the RAM.
    ready      = 1'b1;
    start      = 1'b1;
    base_addr  = 16'h0020;
    word_count = 16'd4;
    step();
    start = 1'b0;
    reset = 1'b1;
    step();
    check_reset_vals("reset_in_wait");
    reset = 1'b0;
    check_quiet("after_reset_wait");

    // Reset while the L=1 instance holds a word under backpressure.
    ready      = 1'b0;
    start      = 1'b1;
    base_addr  = 16'h0030;
    word_count = 16'd4;
    step();
    start = 1'b0;
    w = 0;
    while (!valid_w[0] && w < 20) begin
      step();
      w++;
    end
    chk("hold_reached", valid_w[0], 1);
    reset = 1'b1;
    step();
    check_reset_vals("reset_in_hold");
    reset = 1'b0;
    ready = 1'b1;
    check_quiet("after_reset_hold");

    // Full transfer after reset, then randomized transfers.
    run_xfer(16'h0200, 16'd5, 0, 1'b0);
    run_xfer(16'($urandom), 16'($urandom_range(1, 6)), 0, 1'b0);
    repeat (6) begin
      key = 16'($urandom);
      run_xfer(16'($urandom), 16'($urandom_range(1, 6)), 2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
